pipe_step_ctrl: RTL and testbench

Run-control sequencer for the 5-stage MIPS pipeline under debug.
- Accepts run/step/halt/flush commands from the debug front end over a valid/ready handshake.
- Drives a global enable to every pipeline register (fetch through WB) and a flush line.
- Stops automatically when the halt instruction retires in WB.
- Counts executed cycles for the debug readout.

---
 rtl/pipe_debug_pkg.sv | 37 +++
 rtl/pipe_step_ctrl_sat_counter.sv | 22 ++
 rtl/pipe_step_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_step_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_debug_pkg.sv
// Shared definitions for the pipeline run-control block: debug command codes,
// controller state encoding and the Moore output decode used by pipe_step_ctrl.
package pipe_debug_pkg;

    localparam logic [1:0] CMD_RUN   = 2'd0;
    localparam logic [1:0] CMD_STEP  = 2'd1;
    localparam logic [1:0] CMD_HALT  = 2'd2;
    localparam logic [1:0] CMD_FLUSH = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic pipeEnable;
        logic pipeFlush;
        logic running;
        logic done;
        logic cmdReady;
    } ctrlOut_t;

    // Output values that belong to a given controller state
    function automatic ctrlOut_t decodeState(input state_t s);
        ctrlOut_t o;
        o.pipeEnable = (s == ST_RUN) || (s == ST_STEP) || (s == ST_FLUSH);
        o.pipeFlush  = (s == ST_FLUSH);
        o.running    = (s == ST_RUN);
        o.done       = (s == ST_DONE);
        o.cmdReady   = (s == ST_IDLE) || (s == ST_RUN) || (s == ST_DONE);
        return o;
    endfunction

endpackage

// File: rtl/pipe_step_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of
// wrapping so a long debug run never reports a small cycle count.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    // Clear wins over enable; increment stops once every bit is set
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_step_ctrl.sv
// Run-control sequencer for the 5-stage pipeline under debug. Accepts
// RUN/STEP/HALT/FLUSH commands over a valid/ready handshake, drives the global
// pipeline enable and flush lines, stops when the halt instruction retires and
// counts executed cycles. Optional macro BREAKPOINT_EN adds a PC breakpoint
// that freezes the pipe and drops back to IDLE while running.
module pipe_step_ctrl
    import pipe_debug_pkg::*;
#(
    parameter int CNT_WIDTH    = 32,
    parameter int FLUSH_CYCLES = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmdValid,
    input  logic [1:0]           cmdCode,
    output logic                 cmdReady,
    input  logic                 haltWB,
`ifdef BREAKPOINT_EN
    input  logic                 bpArm,
    input  logic [31:0]          bpAddr,
    input  logic [31:0]          pcFE,
`endif
    output logic                 pipeEnable,
    output logic                 pipeFlush,
    output logic                 running,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] cycleCount
);

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

    state_t        state;
    state_t        nextState;
    logic [FW-1:0] flushCnt;
    logic [FW-1:0] flushNext;
    ctrlOut_t      outReg;
    logic          accept;
    logic          bpHit;
    logic          cntClear;
    logic          cntEnable;

    assign accept = cmdValid && outReg.cmdReady;

`ifdef BREAKPOINT_EN
    logic firstRun;

    assign bpHit = (state == ST_RUN) && !firstRun && bpArm && (pcFE == bpAddr)
                 && !(accept && ((cmdCode == CMD_HALT) || (cmdCode == CMD_FLUSH)));
`else
    assign bpHit = 1'b0;
`endif

    // Next-state and flush-counter decode from the current state and command
    always_comb begin
        nextState = state;
        flushNext = flushCnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (cmdCode)
                        CMD_RUN:   nextState = ST_RUN;
                        CMD_STEP:  nextState = ST_STEP;
                        CMD_FLUSH: begin
                            nextState = ST_FLUSH;
                            flushNext = FLUSH_LOAD;
                        end
                        default:   nextState = ST_IDLE;
                    endcase
                end
            end
            ST_RUN: begin
                if (bpHit) begin
                    nextState = ST_IDLE;
                end else if (haltWB) begin
                    nextState = ST_DONE;
                end else if (accept) begin
                    if (cmdCode == CMD_HALT) begin
                        nextState = ST_IDLE;
                    end else if (cmdCode == CMD_FLUSH) begin
                        nextState = ST_FLUSH;
                        flushNext = FLUSH_LOAD;
                    end
                end
            end
            ST_STEP: begin
                nextState = haltWB ? ST_DONE : ST_IDLE;
            end
            ST_FLUSH: begin
                if (flushCnt == '0) begin
                    nextState = ST_IDLE;
                end else begin
                    flushNext = flushCnt - FW'(1);
                end
            end
            ST_DONE: begin
                if (accept && (cmdCode == CMD_FLUSH)) begin
                    nextState = ST_FLUSH;
                    flushNext = FLUSH_LOAD;
                end
            end
            default: begin
                nextState = ST_IDLE;
            end
        endcase
    end

    // State register with outputs registered from the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            flushCnt <= '0;
            outReg   <= decodeState(ST_IDLE);
`ifdef BREAKPOINT_EN
            firstRun <= 1'b0;
`endif
        end else begin
            state    <= nextState;
            flushCnt <= flushNext;
            outReg   <= decodeState(nextState);
`ifdef BREAKPOINT_EN
            firstRun <= (state != ST_RUN) && (nextState == ST_RUN);
`endif
        end
    end

    assign pipeEnable = outReg.pipeEnable && !bpHit;
    assign pipeFlush  = outReg.pipeFlush;
    assign running    = outReg.running;
    assign done       = outReg.done;
    assign cmdReady   = outReg.cmdReady;

    // The count reads zero for the whole flush window and only counts real work
    assign cntClear  = (state == ST_FLUSH) || (nextState == ST_FLUSH);
    assign cntEnable = pipeEnable && (state != ST_FLUSH);

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) cycleCounter (
        .clk    (clk),
        .reset  (reset),
        .clear  (cntClear),
        .enable (cntEnable),
        .count  (cycleCount)
    );

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// Directed bench for pipe_step_ctrl: a 32-bit counter instance and a 4-bit
// counter instance share the same stimulus so saturation can be observed.
module tb_pipe_step_ctrl;
    import pipe_debug_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmdValid = 1'b0;
    logic [1:0]  cmdCode = 2'd0;
    logic        haltWB = 1'b0;
    logic        cmdReady, pipeEnable, pipeFlush, running, done;
    logic [31:0] cycleCount;
    logic        nReady, nEnable, nFlush, nRunning, nDone;
    logic [3:0]  nCount;
`ifdef BREAKPOINT_EN
    logic        bpArm = 1'b0;
    logic [31:0] bpAddr = 32'h0;
    logic [31:0] pcFE = 32'h4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_step_ctrl #(.CNT_WIDTH(32), .FLUSH_CYCLES(5)) dut (
        .clk(clk), .reset(reset), .cmdValid(cmdValid), .cmdCode(cmdCode),
        .cmdReady(cmdReady), .haltWB(haltWB),
`ifdef BREAKPOINT_EN
        .bpArm(bpArm), .bpAddr(bpAddr), .pcFE(pcFE),
`endif
        .pipeEnable(pipeEnable), .pipeFlush(pipeFlush), .running(running),
        .done(done), .cycleCount(cycleCount)
    );

    pipe_step_ctrl #(.CNT_WIDTH(4), .FLUSH_CYCLES(5)) dutNarrow (
        .clk(clk), .reset(reset), .cmdValid(cmdValid), .cmdCode(cmdCode),
        .cmdReady(nReady), .haltWB(haltWB),
`ifdef BREAKPOINT_EN
        .bpArm(bpArm), .bpAddr(bpAddr), .pcFE(pcFE),
`endif
        .pipeEnable(nEnable), .pipeFlush(nFlush), .running(nRunning),
        .done(nDone), .cycleCount(nCount)
    );

    // Drive command and halt inputs for the next rising edge
    task automatic applyStimulus(input logic v, input logic [1:0] code, input logic h);
        cmdValid = v;
        cmdCode  = code;
        haltWB   = h;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b0, CMD_RUN, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int enCount;
        enCount = 0;
        doReset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pipeEnable) enCount++;
        end
        checks++;
        if (enCount !== 0) begin errors++; $display("[TB] FAIL reset_idle_enable: got %0d enable cycles, expected 0", enCount); end
        checks++;
        if (cmdReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmdReady: got %b expected 1", cmdReady); end
        checks++;
        if (cycleCount !== 32'd0) begin errors++; $display("[TB] FAIL reset_cycleCount: got %0d expected 0", cycleCount); end
        checks++;
        if (done !== 1'b0 || running !== 1'b0 || pipeFlush !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_flags: got done=%b running=%b flush=%b expected 0/0/0", done, running, pipeFlush);
        end
    endtask

    task automatic test_step();
        int pulses;
        pulses = 0;
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1'b1, CMD_STEP, 1'b0);
            @(negedge clk);
            applyStimulus(1'b0, CMD_RUN, 1'b0);
            if (pipeEnable) pulses++;
            checks++;
            if (cmdReady !== 1'b0) begin errors++; $display("[TB] FAIL step_cmdReady: got %b expected 0 (step %0d)", cmdReady, s); end
            for (int g = 0; g < 2; g++) begin
                @(negedge clk);
                if (pipeEnable) pulses++;
            end
        end
        checks++;
        if (pulses !== 3) begin errors++; $display("[TB] FAIL step_pulses: got %0d expected 3", pulses); end
        checks++;
        if (cycleCount !== 32'd3) begin errors++; $display("[TB] FAIL step_cycleCount: got %0d expected 3", cycleCount); end
    endtask

    task automatic test_run_halt();
        int enCount;
        enCount = 0;
        doReset();
        applyStimulus(1'b1, CMD_RUN, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (pipeEnable) enCount++;
            if (i == 20) applyStimulus(1'b1, CMD_HALT, 1'b0);
            else         applyStimulus(1'b0, CMD_RUN, 1'b0);
        end
        @(negedge clk);
        applyStimulus(1'b0, CMD_RUN, 1'b0);
        checks++;
        if (enCount !== 20) begin errors++; $display("[TB] FAIL run_enable_cycles: got %0d expected 20", enCount); end
        checks++;
        if (cycleCount !== 32'd20) begin errors++; $display("[TB] FAIL run_cycleCount: got %0d expected 20", cycleCount); end
        checks++;
        if (running !== 1'b0 || pipeEnable !== 1'b0 || cmdReady !== 1'b1) begin
            errors++; $display("[TB] FAIL run_halt_idle: got running=%b en=%b ready=%b expected 0/0/1", running, pipeEnable, cmdReady);
        end
    endtask

    task automatic test_halt_wb();
        doReset();
        applyStimulus(1'b1, CMD_RUN, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 7) applyStimulus(1'b1, CMD_HALT, 1'b1);
            else        applyStimulus(1'b0, CMD_RUN, 1'b0);
        end
        @(negedge clk);
        applyStimulus(1'b1, CMD_RUN, 1'b0);
        checks++;
        if (done !== 1'b1 || pipeEnable !== 1'b0 || running !== 1'b0) begin
            errors++; $display("[TB] FAIL haltwb_done: got done=%b en=%b running=%b expected 1/0/0", done, pipeEnable, running);
        end
        checks++;
        if (cycleCount !== 32'd7) begin errors++; $display("[TB] FAIL haltwb_cycleCount: got %0d expected 7", cycleCount); end
        @(negedge clk);
        applyStimulus(1'b1, CMD_STEP, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, CMD_RUN, 1'b0);
        checks++;
        if (done !== 1'b1 || pipeEnable !== 1'b0 || cycleCount !== 32'd7) begin
            errors++; $display("[TB] FAIL done_ignores_run: got done=%b en=%b count=%0d expected 1/0/7", done, pipeEnable, cycleCount);
        end
    endtask

    task automatic test_flush_from_done();
        int flushCycles;
        logic badFlush;
        flushCycles = 0;
        badFlush = 1'b0;
        applyStimulus(1'b1, CMD_FLUSH, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (pipeFlush) flushCycles++;
            if (cmdReady !== 1'b0 || cycleCount !== 32'd0 || done !== 1'b0 || pipeEnable !== 1'b1) badFlush = 1'b1;
            applyStimulus(1'b0, CMD_RUN, i == 2);
        end
        @(negedge clk);
        applyStimulus(1'b0, CMD_RUN, 1'b0);
        checks++;
        if (flushCycles !== 5) begin errors++; $display("[TB] FAIL flush_length: got %0d expected 5", flushCycles); end
        checks++;
        if (badFlush !== 1'b0) begin errors++; $display("[TB] FAIL flush_outputs: got bad=%b expected 0 (ready/count/done/en)", badFlush); end
        checks++;
        if (pipeFlush !== 1'b0 || done !== 1'b0 || pipeEnable !== 1'b0 || cmdReady !== 1'b1 || cycleCount !== 32'd0) begin
            errors++; $display("[TB] FAIL flush_exit_idle: got flush=%b done=%b en=%b ready=%b count=%0d expected 0/0/0/1/0",
                               pipeFlush, done, pipeEnable, cmdReady, cycleCount);
        end
    endtask

    task automatic test_step_halt();
        doReset();
        applyStimulus(1'b1, CMD_STEP, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, CMD_RUN, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, CMD_RUN, 1'b0);
        checks++;
        if (done !== 1'b1 || pipeEnable !== 1'b0 || cycleCount !== 32'd1) begin
            errors++; $display("[TB] FAIL step_haltwb: got done=%b en=%b count=%0d expected 1/0/1", done, pipeEnable, cycleCount);
        end
    endtask

    task automatic test_saturate();
        doReset();
        applyStimulus(1'b1, CMD_RUN, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 17) begin
                checks++;
                if (nCount !== 4'd15) begin errors++; $display("[TB] FAIL sat_reach: got %0d expected 15", nCount); end
            end
            if (i == 20) applyStimulus(1'b1, CMD_HALT, 1'b0);
            else         applyStimulus(1'b0, CMD_RUN, 1'b0);
        end
        @(negedge clk);
        applyStimulus(1'b0, CMD_RUN, 1'b0);
        checks++;
        if (nCount !== 4'd15 || cycleCount !== 32'd20) begin
            errors++; $display("[TB] FAIL sat_hold: got narrow=%0d wide=%0d expected 15/20", nCount, cycleCount);
        end
    endtask

    task automatic test_reset_mid_flush();
        applyStimulus(1'b1, CMD_FLUSH, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, CMD_RUN, 1'b0);
        checks++;
        if (pipeFlush !== 1'b1) begin errors++; $display("[TB] FAIL midflush_enter: got %b expected 1", pipeFlush); end
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b1, CMD_RUN, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, CMD_RUN, 1'b0);
        checks++;
        if (pipeFlush !== 1'b0 || pipeEnable !== 1'b0 || cmdReady !== 1'b1) begin
            errors++; $display("[TB] FAIL midflush_reset: got flush=%b en=%b ready=%b expected 0/0/1", pipeFlush, pipeEnable, cmdReady);
        end
        @(negedge clk);
        checks++;
        if (running !== 1'b0 || pipeEnable !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_drops_cmd: got running=%b en=%b expected 0/0", running, pipeEnable);
        end
    endtask

    // Scenario sequence followed by the single summary line
    initial begin
        $display("[TB] starting pipe_step_ctrl directed tests");
        test_reset();
        test_step();
        test_run_halt();
        test_halt_wb();
        test_flush_from_done();
        test_step_halt();
        test_saturate();
        test_reset_mid_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
